// File: rtl/step_rate_gen_pkg.sv
// ----------------------------------------------------------------------------
// step_rate_gen_pkg : shared widths, level limits and divider defaults
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package step_rate_gen_pkg;

  localparam int              LEVEL_W   = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;
  localparam logic [LEVEL_W-1:0] LEVEL_MIN = 3'd0;

  // Board build: 8 Hz base step and 10 ms debounce at 50 MHz
  localparam int DEF_BASE_DIV  = 6_250_000;
  localparam int DEF_DB_CYCLES = 500_000;
  localparam int DEF_CNT_W     = 23;

  // Shortened timing for simulation
  localparam int TB_BASE_DIV   = 16;
  localparam int TB_DB_CYCLES  = 4;

  typedef logic [LEVEL_W-1:0] level_t;

  // Saturating up/down step; simultaneous up and down cancel
  function automatic level_t level_step(input level_t lvl, input logic up, input logic dn);
    level_t nxt;
    nxt = lvl;
    if (up && !dn && (lvl != LEVEL_MAX)) begin
      nxt = lvl + 1'b1;
    end else if (dn && !up && (lvl != LEVEL_MIN)) begin
      nxt = lvl - 1'b1;
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_rate_gen_key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce : 2-FF synchroniser, stability counter, one-cycle press pulse
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module key_debounce #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic R,
  input  logic key_n,
  output logic pressed
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            pressed_q, pressed_d;

  // cnt_q counts consecutive synced samples that disagree with the accepted state
  always_comb begin
    sync_d    = {sync_q[0], key_n};
    db_d      = db_q;
    cnt_d     = '0;
    pressed_d = 1'b0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == DB_LAST) begin
        db_d      = sync_q[1];
        pressed_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      db_q      <= 1'b1;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed = pressed_q;

endmodule

`default_nettype wire

// File: rtl/step_rate_gen.sv
// ----------------------------------------------------------------------------
// step_rate_gen : key-controlled step pulse generator (speed level + pause)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module step_rate_gen
  import step_rate_gen_pkg::*;
#(
  parameter int BASE_DIV   = DEF_BASE_DIV,
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int LEVEL_INIT = 0,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               R,
  input  logic               key_fast_n,
  input  logic               key_slow_n,
  input  logic               key_pause_n,
  output logic               step,
  output logic [LEVEL_W-1:0] level,
  output logic               paused
);

  localparam logic [CNT_W-1:0] BASE_DIV_C = CNT_W'(BASE_DIV);

  logic [2:0] keys_n;
  logic [2:0] press;   // [0]=fast, [1]=slow, [2]=pause

  assign keys_n = {key_pause_n, key_slow_n, key_fast_n};

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_key_debounce (
      .clk     (clk),
      .R       (R),
      .key_n   (keys_n[i]),
      .pressed (press[i])
    );
  end

  level_t           level_q, level_d;
  logic             paused_q, paused_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] div_raw, div_m1;

  // A shift that underflows to zero is treated as DIV=1
  always_comb begin
    div_raw = BASE_DIV_C >> level_q;
    div_m1  = (div_raw == '0) ? '0 : (div_raw - 1'b1);
  end

  always_comb begin
    level_d  = level_step(level_q, press[0], press[1]);
    paused_d = paused_q ^ press[2];
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    if (level_d != level_q) begin
      cnt_d = '0;
    end else if (!paused_d) begin
      // Freezing on paused_d lets a pause press beat a coinciding terminal count
      if (cnt_q >= div_m1) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      level_q  <= level_t'(LEVEL_INIT);
      paused_q <= 1'b0;
      cnt_q    <= '0;
      step_q   <= 1'b0;
    end else begin
      level_q  <= level_d;
      paused_q <= paused_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
    end
  end

  assign step   = step_q;
  assign level  = level_q;
  assign paused = paused_q;

endmodule

`default_nettype wire

// File: tb/tb_step_rate_gen.sv
// ----------------------------------------------------------------------------
// tb_step_rate_gen : directed bench for step_rate_gen with shortened timing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_step_rate_gen;
  import step_rate_gen_pkg::*;

  logic       clk;
  logic       R;
  logic [2:0] keys_n;   // [0]=fast, [1]=slow, [2]=pause
  logic       step;
  logic [2:0] level;
  logic       paused;

  int total  = 0;
  int passed = 0;

  step_rate_gen #(
    .BASE_DIV   (TB_BASE_DIV),
    .DB_CYCLES  (TB_DB_CYCLES),
    .LEVEL_INIT (0),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .R           (R),
    .key_fast_n  (keys_n[0]),
    .key_slow_n  (keys_n[1]),
    .key_pause_n (keys_n[2]),
    .step        (step),
    .level       (level),
    .paused      (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until step is seen (bounded); exp < 0 only synchronises
  task automatic wait_step(input int exp, input string tag);
    int n;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while ((step !== 1'b1) && (n < 40));
    if (exp >= 0) chk(tag, n, exp);
    else          chk({tag, "_seen"}, 32'(step), 1);
  endtask

  task automatic press(input int k);
    keys_n[k] = 1'b0;
    cyc(10);
    keys_n[k] = 1'b1;
    cyc(10);
  endtask

  initial begin
    int nsteps;
    R      = 1'b1;
    keys_n = 3'b111;
    cyc(3);
    chk("rst_step",   32'(step),   0);
    chk("rst_level",  32'(level),  0);
    chk("rst_paused", 32'(paused), 0);
    #1 R = 1'b0;

    // Idle run at level 0
    wait_step(16, "first_step");
    wait_step(16, "step_32");
    wait_step(16, "step_48");
    chk("idle_level", 32'(level), 0);

    // Clean fast press: level moves 7 edges after the key edge, count restarts
    keys_n[0] = 1'b0;
    cyc(6);
    chk("fast_not_yet", 32'(level), 0);
    cyc(1);
    chk("fast_level1", 32'(level), 1);
    cyc(3);
    keys_n[0] = 1'b1;
    wait_step(5, "l1_first_step");
    wait_step(8, "l1_period");
    chk("fast_single_inc", 32'(level), 1);

    // Bouncing fast key then steady low
    keys_n[0] = 1'b0; cyc(1);
    keys_n[0] = 1'b1; cyc(1);
    keys_n[0] = 1'b0; cyc(1);
    keys_n[0] = 1'b1; cyc(1);
    keys_n[0] = 1'b0;
    cyc(6);
    chk("bounce_no_early", 32'(level), 1);
    cyc(1);
    chk("bounce_inc", 32'(level), 2);
    cyc(3);
    keys_n[0] = 1'b1;
    cyc(10);
    chk("bounce_single", 32'(level), 2);

    // Saturation at the top, DIV clamps to 1
    for (int i = 0; i < 8; i++) press(0);
    chk("sat_level7", 32'(level), 7);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("l7_every_cycle", 32'(step), 1);
    end
    press(1);
    chk("slow_level6", 32'(level), 6);
    for (int i = 0; i < 7; i++) press(1);
    chk("sat_level0", 32'(level), 0);

    // Saturated slow press must not restart the period
    wait_step(-1, "sync_sat");
    keys_n[1] = 1'b0;
    wait_step(16, "sat_no_disturb");
    keys_n[1] = 1'b1;
    cyc(10);

    // Pause with count held at 5, then resume
    wait_step(-1, "sync_pause");
    cyc(15);
    keys_n[2] = 1'b0;
    cyc(1);
    chk("step_before_pause", 32'(step), 1);
    cyc(6);
    chk("paused_set", 32'(paused), 1);
    cyc(3);
    keys_n[2] = 1'b1;
    nsteps = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (step) nsteps++;
    end
    chk("no_step_paused", nsteps, 0);
    keys_n[2] = 1'b0;
    cyc(7);
    chk("resumed", 32'(paused), 0);
    wait_step(10, "resume_step");
    keys_n[2] = 1'b1;
    cyc(10);

    // Pause press coinciding with the terminal count
    wait_step(-1, "sync_pause_b");
    cyc(9);
    keys_n[2] = 1'b0;
    cyc(7);
    chk("pause_beats_step", 32'(step), 0);
    chk("paused_b", 32'(paused), 1);
    cyc(3);
    keys_n[2] = 1'b1;
    cyc(10);
    keys_n[2] = 1'b0;
    cyc(7);
    chk("resume_at_last", 32'(step), 1);
    keys_n[2] = 1'b1;
    cyc(10);

    // Simultaneous fast and slow at level 3
    for (int i = 0; i < 3; i++) press(0);
    chk("level3", 32'(level), 3);
    keys_n[1:0] = 2'b00;
    cyc(10);
    keys_n[1:0] = 2'b11;
    cyc(10);
    chk("fast_slow_same", 32'(level), 3);
    wait_step(-1, "sync_l3");
    wait_step(2, "div_level3");

    // Asynchronous reset while step is high
    R = 1'b1;
    #1;
    chk("reset_drops_step", 32'(step),   0);
    chk("reset_level",      32'(level),  0);
    chk("reset_paused",     32'(paused), 0);
    #1 R = 1'b0;
    press(2);
    chk("pause_again", 32'(paused), 1);
    R = 1'b1;
    #1;
    chk("reset_clears_pause", 32'(paused), 0);
    #1 R = 1'b0;
    wait_step(16, "post_reset_first");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
